// File: rtl/seq_detect_param_if.sv
// Bus bundle for seq_detect_param: serial input stream, pattern load, counter clear
// and the match outputs.
interface seq_detect_param_if #(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned CNT_W = 8
);
   logic             din_valid;
   logic             din;
   logic             overlap;
   logic             pat_load;
   logic [PAT_W-1:0] pat_in;
   logic             cnt_clr;
   logic             dout;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;

   modport master (
      output din_valid, din, overlap, pat_load, pat_in, cnt_clr,
      input  dout, match_cnt, cnt_sat
   );

   modport slave (
      input  din_valid, din, overlap, pat_load, pat_in, cnt_clr,
      output dout, match_cnt, cnt_sat
   );
endinterface

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, Mealy match pulse,
// overlapping/non-overlapping modes and a saturating match counter.
module seq_detect_param #(
   parameter int unsigned     PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(4'b1010),
   parameter int unsigned     CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   seq_detect_param_if.slave  bus
);
   localparam int unsigned FILL_W   = $clog2(PAT_W);
   localparam int unsigned FILL_MAX = PAT_W - 1;

   logic [PAT_W-1:0] pat_r;
   logic [PAT_W-2:0] hist;
   logic [FILL_W-1:0] fill;
   logic [CNT_W-1:0] match_cnt_r;
   logic [PAT_W-1:0] window;
   logic             full;
   logic             match;

   // Candidate window: held history plus the bit arriving this cycle
   assign window = {hist, bus.din};
   assign full   = (fill == FILL_W'(FILL_MAX));
   assign match  = bus.din_valid & ~bus.pat_load & full & (window == pat_r);

   assign bus.dout      = match & ~rst;
   assign bus.match_cnt = match_cnt_r;
   assign bus.cnt_sat   = &match_cnt_r;

   // Pattern, history and fill level; a load restarts the search from scratch
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_r <= PATTERN;
         hist  <= '0;
         fill  <= '0;
      end else if (bus.pat_load) begin
         pat_r <= bus.pat_in;
         hist  <= '0;
         fill  <= '0;
      end else if (bus.din_valid) begin
         hist <= window[PAT_W-2:0];
         if (match) begin
            if (!bus.overlap) fill <= '0;
         end else if (!full) begin
            fill <= FILL_W'(fill + 1'b1);
         end
      end
   end

   // Saturating match counter; clear beats a coincident match
   always_ff @(posedge clk) begin
      if (rst || bus.cnt_clr) begin
         match_cnt_r <= '0;
      end else if (bus.dout && !(&match_cnt_r)) begin
         match_cnt_r <= CNT_W'(match_cnt_r + 1'b1);
      end
   end
endmodule
